add_mul_4_bit_sched: RTL and testbench

- Round-robin scheduler that shares one combinational add_mul_4_bit datapath between NUM_REQ requesters.
- Each requester issues add or multiply jobs over a valid/ready handshake.
- The scheduler registers the operands, drives the shared datapath, captures its 8-bit result and returns it tagged with the requester id over a valid/ready response channel.
- Placed between client blocks and the single arithmetic unit.

---
 rtl/add_mul_4_bit_sched.sv | 172 +++++++++++++++++
 tb/tb_add_mul_4_bit_sched.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/add_mul_4_bit_sched.sv
// Round-robin scheduler sharing one combinational add/multiply datapath between NUM_REQ requesters.
// Define ADD_MUL_4_BIT_SCHED_STATS_EN to add saturating add/multiply response counters.
module add_mul_4_bit_sched #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ-1:0]     req_op,
   input  logic [4*NUM_REQ-1:0]   req_a,
   input  logic [4*NUM_REQ-1:0]   req_b,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [7:0]             resp_data,
   output logic [ID_W-1:0]        resp_id,
   output logic                   resp_op,
   output logic [3:0]             dp_a,
   output logic [3:0]             dp_b,
   output logic                   dp_operation,
   input  logic [7:0]             dp_result,
   output logic                   busy
`ifdef ADD_MUL_4_BIT_SCHED_STATS_EN
   ,
   output logic [15:0]            stat_add_cnt,
   output logic [15:0]            stat_mul_cnt
`endif
);

   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_e;

   state_e          state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0] id_q, id_d;
   logic [3:0]      dp_a_q, dp_a_d, dp_b_q, dp_b_d;
   logic            dp_op_q, dp_op_d;
   logic            resp_valid_q, resp_valid_d;
   logic [7:0]      resp_data_q, resp_data_d;
   logic [ID_W-1:0] resp_id_q, resp_id_d;
   logic            resp_op_q, resp_op_d;

   int              scan_idx;
   logic            win_found;
   logic [ID_W-1:0] win_id;
   logic            grant_ok;
   logic            grant;

   // First valid requester strictly after the last winner, wrapping modulo NUM_REQ.
   always_comb begin
      scan_idx  = 0;
      win_found = 1'b0;
      win_id    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!win_found && req_valid[scan_idx]) begin
            win_found = 1'b1;
            win_id    = ID_W'(scan_idx);
         end
      end
   end

   assign grant_ok = (state_q == ST_IDLE) || ((state_q == ST_RESP) && resp_ready);
   assign grant    = grant_ok && win_found;

   always_comb begin
      req_ready = '0;
      if (grant) req_ready[win_id] = 1'b1;
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      id_d         = id_q;
      dp_a_d       = dp_a_q;
      dp_b_d       = dp_b_q;
      dp_op_d      = dp_op_q;
      resp_valid_d = resp_valid_q;
      resp_data_d  = resp_data_q;
      resp_id_d    = resp_id_q;
      resp_op_d    = resp_op_q;
      // A grant latches the winner's job onto the shared datapath; dp_* hold otherwise.
      if (grant) begin
         dp_a_d   = req_a[4*int'(win_id) +: 4];
         dp_b_d   = req_b[4*int'(win_id) +: 4];
         dp_op_d  = req_op[win_id];
         id_d     = win_id;
         rr_ptr_d = win_id;
      end
      case (state_q)
         ST_IDLE: if (grant) state_d = ST_EXEC;
         ST_EXEC: begin
            resp_data_d  = dp_result;
            resp_id_d    = id_q;
            resp_op_d    = dp_op_q;
            resp_valid_d = 1'b1;
            state_d      = ST_RESP;
         end
         ST_RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = grant ? ST_EXEC : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= ID_W'(NUM_REQ - 1);
         id_q         <= '0;
         dp_a_q       <= '0;
         dp_b_q       <= '0;
         dp_op_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_id_q    <= '0;
         resp_op_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         id_q         <= id_d;
         dp_a_q       <= dp_a_d;
         dp_b_q       <= dp_b_d;
         dp_op_q      <= dp_op_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_id_q    <= resp_id_d;
         resp_op_q    <= resp_op_d;
      end
   end

   assign resp_valid   = resp_valid_q;
   assign resp_data    = resp_data_q;
   assign resp_id      = resp_id_q;
   assign resp_op      = resp_op_q;
   assign dp_a         = dp_a_q;
   assign dp_b         = dp_b_q;
   assign dp_operation = dp_op_q;
   assign busy         = (state_q != ST_IDLE);

`ifdef ADD_MUL_4_BIT_SCHED_STATS_EN
   logic [15:0] add_cnt_q, add_cnt_d, mul_cnt_q, mul_cnt_d;
   logic        resp_fire;

   assign resp_fire = resp_valid_q && resp_ready;

   // Counters stick at all-ones rather than wrapping.
   always_comb begin
      add_cnt_d = add_cnt_q;
      mul_cnt_d = mul_cnt_q;
      if (resp_fire && !resp_op_q && (add_cnt_q != 16'hFFFF)) add_cnt_d = add_cnt_q + 16'd1;
      if (resp_fire &&  resp_op_q && (mul_cnt_q != 16'hFFFF)) mul_cnt_d = mul_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         add_cnt_q <= '0;
         mul_cnt_q <= '0;
      end else begin
         add_cnt_q <= add_cnt_d;
         mul_cnt_q <= mul_cnt_d;
      end
   end

   assign stat_add_cnt = add_cnt_q;
   assign stat_mul_cnt = mul_cnt_q;
`endif

endmodule

// File: tb/tb_add_mul_4_bit_sched.sv
// Directed bench for add_mul_4_bit_sched with a behavioural model of the shared datapath.
module tb_add_mul_4_bit_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid, req_ready, req_op;
   logic [15:0] req_a, req_b;
   logic        resp_valid, resp_ready, resp_op;
   logic [7:0]  resp_data;
   logic [1:0]  resp_id;
   logic [3:0]  dp_a, dp_b;
   logic        dp_operation;
   logic [7:0]  dp_result;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] rot_data [4] = '{8'h03, 8'h06, 8'h07, 8'h14};

   always #5 clk = ~clk;

   // External arithmetic unit: product, or zero-extended 5-bit sum.
   assign dp_result = dp_operation ? ({4'd0, dp_a} * {4'd0, dp_b}) : {3'd0, {1'b0, dp_a} + {1'b0, dp_b}};

   add_mul_4_bit_sched #(.NUM_REQ(4), .ID_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_id(resp_id), .resp_op(resp_op),
      .dp_a(dp_a), .dp_b(dp_b), .dp_operation(dp_operation), .dp_result(dp_result),
      .busy(busy)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int idx, input logic op, input logic [3:0] a, input logic [3:0] b);
      req_op[idx]       = op;
      req_a[4*idx +: 4] = a;
      req_b[4*idx +: 4] = b;
   endtask

   task automatic issue_one(input int idx, input logic op, input logic [3:0] a, input logic [3:0] b,
                            input logic [7:0] exp);
      req_valid = '0;
      set_req(idx, op, a, b);
      req_valid[idx] = 1'b1;
      #1;
      check_val("single_ready", req_ready, 32'(1 << idx));
      tick();
      req_valid = '0;
      check_val("single_busy", busy, 1);
      check_val("single_exec_nvalid", resp_valid, 0);
      check_val("single_dp_a", dp_a, a);
      check_val("single_dp_op", dp_operation, op);
      tick();
      check_val("single_valid", resp_valid, 1);
      check_val("single_data", resp_data, exp);
      check_val("single_id", resp_id, idx);
      check_val("single_op", resp_op, op);
      tick();
      check_val("single_done_valid", resp_valid, 0);
      check_val("single_done_busy", busy, 0);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
      tick();
      tick();
      check_val("rst_resp_valid", resp_valid, 0);
      check_val("rst_resp_data", resp_data, 0);
      check_val("rst_resp_id", resp_id, 0);
      check_val("rst_dp", {dp_a, dp_b, 3'd0, dp_operation}, 0);
      check_val("rst_busy", busy, 0);
      rst_n = 1'b1;
      tick();
      check_val("idle_ready", req_ready, 0);
      check_val("idle_busy", busy, 0);

      // Directed single jobs.
      resp_ready = 1'b1;
      issue_one(1, 1'b0, 4'd15, 4'd15, 8'h1E);
      issue_one(2, 1'b1, 4'd15, 4'd15, 8'hE1);
      issue_one(3, 1'b1, 4'd7,  4'd0,  8'h00);

      // All requesters active: strict rotation starting after requester 3.
      for (int i = 0; i < 4; i++) set_req(i, 1'(i % 2), 4'(i + 1), 4'(i + 2));
      req_valid = 4'b1111;
      #1;
      check_val("rot_first_ready", req_ready, 4'b0001);
      tick();
      for (int j = 0; j < 5; j++) begin
         check_val("rot_exec_no_grant", req_ready, 0);
         tick();
         check_val("rot_valid", resp_valid, 1);
         check_val("rot_id", resp_id, j % 4);
         check_val("rot_data", resp_data, rot_data[j % 4]);
         if (j < 4) begin
            check_val("rot_next_ready", req_ready, 32'(1 << ((j + 1) % 4)));
         end else begin
            req_valid = '0;
            #1;
            check_val("rot_last_ready", req_ready, 0);
         end
         tick();
      end
      check_val("rot_idle", busy, 0);

      // Backpressure holds the response and blocks new grants.
      resp_ready = 1'b0;
      set_req(2, 1'b0, 4'd9, 4'd5);
      set_req(3, 1'b1, 4'd3, 4'd3);
      req_valid = 4'b1100;
      #1;
      check_val("bp_ready", req_ready, 4'b0100);
      tick();
      tick();
      for (int c = 0; c < 5; c++) begin
         check_val("bp_valid", resp_valid, 1);
         check_val("bp_data", resp_data, 8'h0E);
         check_val("bp_id", resp_id, 2);
         check_val("bp_no_grant", req_ready, 0);
         tick();
      end
      resp_ready = 1'b1;
      #1;
      check_val("bp_release_ready", req_ready, 4'b1000);
      tick();
      req_valid = '0;
      check_val("bp_after_valid", resp_valid, 0);
      check_val("bp_after_busy", busy, 1);
      tick();
      check_val("bp_next_data", resp_data, 8'h09);
      check_val("bp_next_id", resp_id, 3);
      check_val("bp_next_op", resp_op, 1);
      tick();

      // Reset while a job is executing.
      set_req(1, 1'b0, 4'd4, 4'd4);
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
      check_val("mid_busy_before", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_busy", busy, 0);
      check_val("mid_rst_dp_a", dp_a, 0);
      check_val("mid_rst_valid", resp_valid, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      check_val("mid_no_resp", resp_valid, 0);
      for (int i = 0; i < 4; i++) set_req(i, 1'(i % 2), 4'(i + 1), 4'(i + 2));
      req_valid = 4'b1111;
      #1;
      check_val("post_rst_ready", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      tick();
      check_val("post_rst_id", resp_id, 0);
      check_val("post_rst_data", resp_data, 8'h03);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
